role_udp_echo_saf: RTL and testbench

ROLE_UDP_ECHO_SAF -- requirements
Module: role_udp_echo_saf

---
 rtl/role_udp_echo_saf_if.sv | 43 ++++
 rtl/role_udp_echo_saf.sv | 244 ++++++++++++++++++++++++
 tb/tb_role_udp_echo_saf.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/role_udp_echo_saf_if.sv
`default_nettype none
// ============================================================================
// Module   : role_udp_echo_saf_if
// Purpose  : UDP stream bundle for one direction. It carries one AXI-Stream
//            data channel and one 64-bit meta channel.
// Ports    : data{Tdata,Tkeep,Tvalid,Tlast}/dataTready   AXIS payload
//            meta{Tdata,Tvalid,Tkeep,Tlast}/metaTready   AXIS meta word
//            master modport drives payload and meta and receives the readies.
//            slave modport is the mirror image.
// Revision : 1.0  initial release
// ============================================================================
interface role_udp_echo_saf_if #(
   parameter int DATA_W = 64
) ();
   localparam int KEEP_W = DATA_W / 8;

   logic [DATA_W-1:0] dataTdata;
   logic [KEEP_W-1:0] dataTkeep;
   logic              dataTvalid;
   logic              dataTlast;
   logic              dataTready;

   logic [63:0]       metaTdata;
   logic              metaTvalid;
   logic [7:0]        metaTkeep;
   logic              metaTlast;
   logic              metaTready;

   modport master (
      output dataTdata, dataTkeep, dataTvalid, dataTlast,
      input  dataTready,
      output metaTdata, metaTvalid, metaTkeep, metaTlast,
      input  metaTready
   );

   modport slave (
      input  dataTdata, dataTkeep, dataTvalid, dataTlast,
      output dataTready,
      input  metaTdata, metaTvalid, metaTkeep, metaTlast,
      output metaTready
   );
endinterface
`default_nettype wire

// File: rtl/role_udp_echo_saf.sv
`default_nettype none
// ============================================================================
// Module   : role_udp_echo_saf
// Purpose  : Store-and-forward UDP echo role. It receives one meta word and
//            one packet into a local buffer, then sends back the swapped meta
//            (ranks and ports exchanged) followed by the stored packet.
//            Packets longer than DEPTH words are discarded and counted.
// Ports    : piSHL_156_25Clk        clock (rising edge)
//            piSHL_156_25Rst_n      asynchronous active-low reset
//            piMMIO_Ly7_En          role enable
//            siNRC                  Rx data + Rx meta (slave)
//            soNRC                  Tx data + Tx meta (master)
//            poROL_Nrc_Udp_Rx_ports open-port vector (= PORT_MASK)
//            poSHL_Mmio_RdReg       status / version register
// Config   : ROLE_UDP_ECHO_STATS_EN  when defined, packet and drop counters
//            are built and RdReg = {drop_cnt[7:0], pkt_cnt[7:0]}. Otherwise
//            RdReg = VERSION and no counters exist.
// Params   : DATA_W in {64,128,256,512}; DEPTH a power of 2 in 16..4096
// Revision : 1.0  initial release
// ============================================================================
module role_udp_echo_saf #(
   parameter int          DATA_W    = 64,
   parameter int          DEPTH     = 512,
   parameter logic [31:0] PORT_MASK = 32'h0000_0001,
   parameter logic [15:0] VERSION   = 16'hE001
) (
   input  wire logic            piSHL_156_25Clk,
   input  wire logic            piSHL_156_25Rst_n,
   input  wire logic            piMMIO_Ly7_En,
   role_udp_echo_saf_if.slave   siNRC,
   role_udp_echo_saf_if.master  soNRC,
   output logic [31:0]          poROL_Nrc_Udp_Rx_ports,
   output logic [15:0]          poSHL_Mmio_RdReg
);
   localparam int KEEP_W = DATA_W / 8;
   localparam int AW     = $clog2(DEPTH);
   // Buffer word layout: {tdata, tkeep, tlast}
   localparam int WORD_W = DATA_W + KEEP_W + 1;

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_RX_META = 3'd1;
   localparam logic [2:0] c_RX_DATA = 3'd2;
   localparam logic [2:0] c_DRAIN   = 3'd3;
   localparam logic [2:0] c_TX_META = 3'd4;
   localparam logic [2:0] c_TX_DATA = 3'd5;

   logic [1:0]        r_rstSync;
   logic              w_rstDone;
   logic [2:0]        r_state;
   logic [2:0]        w_nextState;
   logic [63:0]       r_meta;
   logic [AW-1:0]     r_wrPtr;
   logic [AW-1:0]     r_rdPtr;
   logic [AW-1:0]     w_rdAddr;
   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_rdWord;

   logic w_rxMetaReady;
   logic w_rxDataReady;
   logic w_txMetaValid;
   logic w_txDataValid;
   logic w_rxMetaHs;
   logic w_rxBeat;
   logic w_txMetaHs;
   logic w_txBeat;
   logic w_full;
   logic w_wrEn;
   logic w_txLast;

   // -------------------------------------------------------------------------
   // Reset release is synchronised. Assertion stays asynchronous everywhere.
   // The FSM may only leave IDLE once both stages have seen reset released.
   // -------------------------------------------------------------------------
   always_ff @(posedge piSHL_156_25Clk or negedge piSHL_156_25Rst_n) begin
      if (!piSHL_156_25Rst_n) begin
         r_rstSync <= 2'b00;
      end else begin
         r_rstSync <= {r_rstSync[0], 1'b1};
      end
   end
   assign w_rstDone = r_rstSync[1];

   // -------------------------------------------------------------------------
   // Handshake qualifiers
   // -------------------------------------------------------------------------
   assign w_rxMetaHs = siNRC.metaTvalid & w_rxMetaReady;
   assign w_rxBeat   = siNRC.dataTvalid & w_rxDataReady;
   assign w_txMetaHs = w_txMetaValid & soNRC.metaTready;
   assign w_txBeat   = w_txDataValid & soNRC.dataTready;
   assign w_txLast   = r_rdWord[0];

   // The last buffer slot accepts only a tlast beat. Any other beat there
   // means the packet cannot fit.
   assign w_full = (r_wrPtr == AW'(DEPTH - 1));
   assign w_wrEn = (r_state == c_RX_DATA) & w_rxBeat & (siNRC.dataTlast | ~w_full);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge piSHL_156_25Clk or negedge piSHL_156_25Rst_n) begin
      if (!piSHL_156_25Rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state. The enable is sampled only in IDLE, so a started packet
   // always runs through to completion.
   // -------------------------------------------------------------------------
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         c_IDLE:    if (piMMIO_Ly7_En && w_rstDone)           w_nextState = c_RX_META;
         c_RX_META: if (w_rxMetaHs)                           w_nextState = c_RX_DATA;
         c_RX_DATA: begin
            if (w_rxBeat) begin
               if (siNRC.dataTlast)                           w_nextState = c_TX_META;
               else if (w_full)                               w_nextState = c_DRAIN;
            end
         end
         c_DRAIN:   if (w_rxBeat && siNRC.dataTlast)          w_nextState = c_IDLE;
         c_TX_META: if (w_txMetaHs)                           w_nextState = c_TX_DATA;
         c_TX_DATA: if (w_txBeat && w_txLast)                 w_nextState = c_IDLE;
         default:                                             w_nextState = c_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs. They depend on the state only, so they all drop in the
   // same instant that reset is asserted.
   // -------------------------------------------------------------------------
   always_comb begin
      w_rxMetaReady = 1'b0;
      w_rxDataReady = 1'b0;
      w_txMetaValid = 1'b0;
      w_txDataValid = 1'b0;
      case (r_state)
         c_RX_META: w_rxMetaReady = 1'b1;
         c_RX_DATA: w_rxDataReady = 1'b1;
         c_DRAIN:   w_rxDataReady = 1'b1;
         c_TX_META: w_txMetaValid = 1'b1;
         c_TX_DATA: w_txDataValid = 1'b1;
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Pointers and captured meta
   // r_rdPtr indexes the word now in r_rdWord. It stays 0 outside TX_DATA,
   // so word 0 is already fetched when TX_DATA begins.
   // -------------------------------------------------------------------------
   always_ff @(posedge piSHL_156_25Clk or negedge piSHL_156_25Rst_n) begin
      if (!piSHL_156_25Rst_n) begin
         r_meta  <= '0;
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_rxMetaHs) begin
            r_meta  <= siNRC.metaTdata;
            r_wrPtr <= '0;
         end else if (w_wrEn) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end

         if (r_state != c_TX_DATA) begin
            r_rdPtr <= '0;
         end else begin
            r_rdPtr <= w_rdAddr;
         end
      end
   end

   // The buffer is read every cycle. On a stall the same address is fetched
   // again, so the output word stays stable. On a handshake the next word is
   // fetched, so there are no bubbles while tready stays high.
   assign w_rdAddr = w_txBeat ? (r_rdPtr + AW'(1)) : r_rdPtr;

   // -------------------------------------------------------------------------
   // Packet buffer (no reset; contents are don't-care after reset)
   // -------------------------------------------------------------------------
   always_ff @(posedge piSHL_156_25Clk) begin
      if (w_wrEn) begin
         r_mem[r_wrPtr] <= {siNRC.dataTdata, siNRC.dataTkeep, siNRC.dataTlast};
      end
   end

   always_ff @(posedge piSHL_156_25Clk) begin
      r_rdWord <= r_mem[w_rdAddr];
   end

   // -------------------------------------------------------------------------
   // Port drive
   // -------------------------------------------------------------------------
   assign siNRC.metaTready = w_rxMetaReady;
   assign siNRC.dataTready = w_rxDataReady;

   assign soNRC.metaTvalid = w_txMetaValid;
   assign soNRC.metaTdata  = {r_meta[47:32], r_meta[63:48], r_meta[15:0], r_meta[31:16]};
   assign soNRC.metaTkeep  = 8'hFF;
   assign soNRC.metaTlast  = 1'b1;

   assign soNRC.dataTvalid = w_txDataValid;
   assign soNRC.dataTdata  = r_rdWord[WORD_W-1 -: DATA_W];
   assign soNRC.dataTkeep  = r_rdWord[KEEP_W:1];
   assign soNRC.dataTlast  = w_txLast;

   assign poROL_Nrc_Udp_Rx_ports = PORT_MASK;

`ifdef ROLE_UDP_ECHO_STATS_EN
   // -------------------------------------------------------------------------
   // Statistics: both counters wrap naturally at 16 bits.
   // -------------------------------------------------------------------------
   logic [15:0] r_pktCnt;
   logic [15:0] r_dropCnt;

   always_ff @(posedge piSHL_156_25Clk or negedge piSHL_156_25Rst_n) begin
      if (!piSHL_156_25Rst_n) begin
         r_pktCnt  <= '0;
         r_dropCnt <= '0;
      end else begin
         if ((r_state == c_TX_DATA) && w_txBeat && w_txLast) begin
            r_pktCnt <= r_pktCnt + 16'd1;
         end
         if ((r_state == c_DRAIN) && w_rxBeat && siNRC.dataTlast) begin
            r_dropCnt <= r_dropCnt + 16'd1;
         end
      end
   end

   assign poSHL_Mmio_RdReg = {r_dropCnt[7:0], r_pktCnt[7:0]};

   logic w_unusedSigs;
   assign w_unusedSigs = ^{siNRC.metaTkeep, siNRC.metaTlast, r_pktCnt[15:8], r_dropCnt[15:8]};
`else
   assign poSHL_Mmio_RdReg = VERSION;

   logic w_unusedSigs;
   assign w_unusedSigs = ^{siNRC.metaTkeep, siNRC.metaTlast};
`endif

endmodule
`default_nettype wire

// File: tb/tb_role_udp_echo_saf.sv
`default_nettype none
// ============================================================================
// Module   : tb_role_udp_echo_saf
// Purpose  : Self-checking bench for role_udp_echo_saf (DATA_W=64, DEPTH=16).
//            Expected Tx meta and data words go into queues as Rx stimulus is
//            driven. They are popped and compared on each Tx handshake.
//            Honours ROLE_UDP_ECHO_STATS_EN for the expected RdReg value.
// Revision : 1.0  initial release
// ============================================================================
module tb_role_udp_echo_saf;
   localparam int          DATA_W    = 64;
   localparam int          KEEP_W    = DATA_W / 8;
   localparam int          DEPTH     = 16;
   localparam int          WORD_W    = DATA_W + KEEP_W + 1;
   localparam int          TMO       = 500;
   localparam logic [31:0] PORT_MASK = 32'h0000_0005;
   localparam logic [15:0] VERSION   = 16'hE001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [31:0] rxPorts;
   logic [15:0] rdReg;

   role_udp_echo_saf_if #(.DATA_W(DATA_W)) rxIf ();
   role_udp_echo_saf_if #(.DATA_W(DATA_W)) txIf ();

   role_udp_echo_saf #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .PORT_MASK (PORT_MASK),
      .VERSION   (VERSION)
   ) dut (
      .piSHL_156_25Clk        (clk),
      .piSHL_156_25Rst_n      (rst_n),
      .piMMIO_Ly7_En          (en),
      .siNRC                  (rxIf),
      .soNRC                  (txIf),
      .poROL_Nrc_Udp_Rx_ports (rxPorts),
      .poSHL_Mmio_RdReg       (rdReg)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nErrors = 0;
   int txMode  = 0;      // 0: Tx readies always high, 1: pattern 1-0-0-1
   int metaSeen = 0;

   logic [WORD_W-1:0] expData[$];
   logic [63:0]       expMeta[$];

   task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] swapMeta(input logic [63:0] m);
      // out = {dst_rank, src_rank, dst_port, src_port}
      return {m[47:32], m[63:48], m[15:0], m[31:16]};
   endfunction

   function automatic logic [15:0] expReg(input logic [7:0] pkt, input logic [7:0] drop);
`ifdef ROLE_UDP_ECHO_STATS_EN
      return {drop, pkt};
`else
      return (pkt == drop) ? VERSION : VERSION;
`endif
   endfunction

   // ---------------- Tx ready driver ----------------
   initial begin
      int cyc;
      logic r;
      cyc = 0;
      txIf.dataTready = 1'b0;
      txIf.metaTready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (txMode == 0) r = 1'b1;
         else             r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         txIf.dataTready = r;
         txIf.metaTready = r;
         cyc++;
      end
   end

   // ---------------- Tx monitor / scoreboard ----------------
   initial begin
      logic              dHold, mHold;
      logic [WORD_W-1:0] dHeld, curWord;
      logic [63:0]       mHeld;
      dHold = 1'b0;
      mHold = 1'b0;
      dHeld = '0;
      mHeld = '0;
      forever begin
         @(negedge clk);
         curWord = {txIf.dataTdata, txIf.dataTkeep, txIf.dataTlast};
         if (!rst_n) begin
            dHold = 1'b0;
            mHold = 1'b0;
         end else begin
            if (dHold) checkVal("tx_data_stall_hold", {txIf.dataTvalid, curWord}, {1'b1, dHeld});
            if (mHold) checkVal("tx_meta_stall_hold", {txIf.metaTvalid, txIf.metaTdata}, {1'b1, mHeld});
            if (txIf.metaTvalid && txIf.metaTready) begin
               metaSeen++;
               checkVal("tx_meta_expected", (expMeta.size() > 0), 1);
               if (expMeta.size() > 0) checkVal("tx_meta", txIf.metaTdata, expMeta.pop_front());
               checkVal("tx_meta_keep_last", {txIf.metaTkeep, txIf.metaTlast}, {8'hFF, 1'b1});
            end
            if (txIf.dataTvalid && txIf.dataTready) begin
               checkVal("tx_data_expected", (expData.size() > 0), 1);
               if (expData.size() > 0) checkVal("tx_data", curWord, expData.pop_front());
            end
            dHold = txIf.dataTvalid & ~txIf.dataTready;
            dHeld = curWord;
            mHold = txIf.metaTvalid & ~txIf.metaTready;
            mHeld = txIf.metaTdata;
         end
      end
   end

   // ---------------- Rx driver helpers (called at posedge+1) ----------------
   task automatic waitRx(input bit isMeta, input string tag);
      int  n;
      logic r;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         r = isMeta ? rxIf.metaTready : rxIf.dataTready;
      end while (!r && n < TMO);
      if (!r) checkVal(tag, r, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic sendPacket(input logic [63:0] meta, input logic [63:0] txMeta, input int nBeats,
                             input logic [7:0] lastKeep, input bit echo, input int stopAfter);
      logic [DATA_W-1:0] d;
      logic [KEEP_W-1:0] k;
      logic              l;
      if (echo) expMeta.push_back(txMeta);
      rxIf.metaTdata  = meta;
      rxIf.metaTvalid = 1'b1;
      waitRx(1'b1, "rx_meta_ready_timeout");
      rxIf.metaTvalid = 1'b0;
      for (int i = 0; i < nBeats && i < stopAfter; i++) begin
         l = (i == nBeats - 1);
         d = {$urandom, $urandom};
         k = l ? lastKeep : 8'hFF;
         rxIf.dataTdata  = d;
         rxIf.dataTkeep  = k;
         rxIf.dataTlast  = l;
         rxIf.dataTvalid = 1'b1;
         if (echo) expData.push_back({d, k, l});
         waitRx(1'b0, "rx_data_ready_timeout");
         rxIf.dataTvalid = 1'b0;
      end
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while ((expMeta.size() != 0 || expData.size() != 0) && n < TMO * 4) begin
         @(posedge clk);
         n++;
      end
      checkVal("scoreboard_drained", expMeta.size() + expData.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // ---------------- Main sequence ----------------
   initial begin
      logic [63:0] m;
      int          seenBefore, n;
      logic        seen;

      rxIf.dataTdata  = '0;
      rxIf.dataTkeep  = '0;
      rxIf.dataTvalid = 1'b0;
      rxIf.dataTlast  = 1'b0;
      rxIf.metaTdata  = '0;
      rxIf.metaTvalid = 1'b0;
      rxIf.metaTkeep  = 8'hFF;
      rxIf.metaTlast  = 1'b1;
      en    = 1'b1;
      rst_n = 1'b0;

      // Reset state
      repeat (4) @(posedge clk);
      #1;
      checkVal("rst_handshakes_idle",
               {rxIf.metaTready, rxIf.dataTready, txIf.metaTvalid, txIf.dataTvalid}, 4'b0000);
      checkVal("rst_rx_ports", rxPorts, PORT_MASK);
      checkVal("rst_rdreg", rdReg, expReg(8'd0, 8'd0));
      rst_n = 1'b1;
      @(negedge clk);
      checkVal("sync_hold_idle", rxIf.metaTready, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      checkVal("rx_ports_run", rxPorts, PORT_MASK);
      checkVal("rx_meta_ready_after_sync", rxIf.metaTready, 1'b1);

      // Basic echo with swapped meta, short last beat
      sendPacket(64'h0002_0001_1234_5678, 64'h0001_0002_5678_1234, 3, 8'h0F, 1'b1, 3);
      waitDone();

      // Tx back-pressure pattern 1-0-0-1
      txMode = 1;
      m = {$urandom, $urandom};
      sendPacket(m, swapMeta(m), 6, 8'h01, 1'b1, 6);
      waitDone();
      txMode = 0;

      // Exactly DEPTH beats fits
      m = {$urandom, $urandom};
      sendPacket(m, swapMeta(m), DEPTH, 8'hFF, 1'b1, DEPTH);
      waitDone();

      // Oversized packet is dropped
      seenBefore = metaSeen;
      m = {$urandom, $urandom};
      sendPacket(m, swapMeta(m), 20, 8'hFF, 1'b0, 20);
      repeat (30) @(posedge clk);
      #1;
      checkVal("overflow_no_tx_meta", metaSeen, seenBefore);
      checkVal("overflow_rdreg", rdReg, expReg(8'd3, 8'd1));

      // Next packet after drop echoes correctly
      m = {$urandom, $urandom};
      sendPacket(m, swapMeta(m), 4, 8'h7F, 1'b1, 4);
      waitDone();
      checkVal("stats_rdreg", rdReg, expReg(8'd4, 8'd1));

      // Reset while beat 2 of a packet is offered
      m = {$urandom, $urandom};
      sendPacket(m, swapMeta(m), 6, 8'hFF, 1'b0, 2);
      rxIf.dataTdata  = {$urandom, $urandom};
      rxIf.dataTkeep  = 8'hFF;
      rxIf.dataTlast  = 1'b0;
      rxIf.dataTvalid = 1'b1;
      @(negedge clk);
      checkVal("in_rx_data_before_rst", rxIf.dataTready, 1'b1);
      rst_n = 1'b0;
      #1;
      checkVal("async_rst_handshakes",
               {rxIf.metaTready, rxIf.dataTready, txIf.metaTvalid, txIf.dataTvalid}, 4'b0000);
      rxIf.dataTvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkVal("rst_mid_rdreg", rdReg, expReg(8'd0, 8'd0));
      checkVal("rst_mid_rx_ports", rxPorts, PORT_MASK);
      rst_n = 1'b1;
      m = {$urandom, $urandom};
      sendPacket(m, swapMeta(m), 3, 8'h03, 1'b1, 3);
      waitDone();

      // Enable dropped during TX_DATA: packet completes, then stays idle
      txMode = 1;
      m = {$urandom, $urandom};
      sendPacket(m, swapMeta(m), 5, 8'h3F, 1'b1, 5);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!txIf.dataTvalid && n < TMO);
      if (!txIf.dataTvalid) checkVal("tx_data_valid_timeout", txIf.dataTvalid, 1'b1);
      en = 1'b0;
      waitDone();
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seen = seen | rxIf.metaTready | rxIf.dataTready;
      end
      checkVal("en_off_rx_not_ready", seen, 1'b0);
      checkVal("en_off_rdreg", rdReg, expReg(8'd2, 8'd0));
      txMode = 0;

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
`default_nettype wire
